bcd_operand_entry: RTL and testbench

//  Operand entry stage directly upstream of the decimal adder/display path.
//  - Three raw pushbuttons are synchronised, debounced and edge-detected.
//  - Two BCD digit registers (A, B), each 0..9, are stepped by the buttons and drive the adder operand inputs.
//  - Holding an increment button auto-repeats. A clear button zeroes both digits.

---
 rtl/bcd_operand_entry.sv | 157 +++++++++++++++
 tb/tb_bcd_operand_entry.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_entry.sv
// Operand entry for the decimal adder: three pushbuttons are synchronised, debounced
// and edge-detected, and they step two BCD digit registers. The A and B buttons auto-repeat.
module bcd_operand_entry #(
  parameter int DB_CYCLES    = 400000,
  parameter int REPEAT_DELAY = 20000000,
  parameter int REPEAT_RATE  = 8000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_clr,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       upd
);

  localparam int NUM_BTN = 3;
  localparam int NUM_REP = 2;
  localparam int DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW     = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, RPT} rep_state_t;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;
  logic [NUM_REP-1:0] db;
  logic [NUM_REP-1:0] inc;
  logic               clr;

  assign raw = {btn_clr, btn_b, btn_a};

  // Per button: 2-FF synchroniser, stable-count debounce, rising-edge detect.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    logic [1:0]     sync_q;
    logic [DBW-1:0] cnt;
    logic           db_q;
    logic           db_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        cnt    <= '0;
        db_q   <= 1'b0;
        db_d   <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], raw[i]};
        db_d   <= db_q;
        if (sync_q[1] == db_q) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          db_q <= sync_q[1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[i] = db_q & ~db_d;

    if (i < NUM_REP) begin : g_db
      assign db[i] = db_q;
    end
  end

  // Auto-repeat for the increment buttons; inc is registered, one cycle after press.
  for (genvar i = 0; i < NUM_REP; i++) begin : g_rep
    localparam logic [RCW-1:0] DLY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST = RCW'(REPEAT_RATE - 1);
    rep_state_t     st, st_n;
    logic [RCW-1:0] cnt, cnt_n;
    logic           inc_q, inc_n;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= IDLE;
        cnt   <= '0;
        inc_q <= 1'b0;
      end else begin
        st    <= st_n;
        cnt   <= cnt_n;
        inc_q <= inc_n;
      end
    end

    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      inc_n = 1'b0;
      case (st)
        IDLE: begin
          if (press[i]) begin
            st_n  = HOLD;
            inc_n = 1'b1;
            cnt_n = '0;
          end
        end
        HOLD: begin
          if (!db[i]) begin
            st_n  = IDLE;
            cnt_n = '0;
          end else if (cnt == DLY_LAST) begin
            st_n  = RPT;
            inc_n = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RPT: begin
          if (!db[i]) begin
            st_n  = IDLE;
            cnt_n = '0;
          end else if (cnt == RATE_LAST) begin
            inc_n = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          st_n  = IDLE;
          cnt_n = '0;
        end
      endcase
    end

    assign inc[i] = inc_q;
  end

  // Clear is delayed one cycle so it lines up with the registered inc pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr <= 1'b0;
    else        clr <= press[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A   <= 4'd0;
      B   <= 4'd0;
      upd <= 1'b0;
    end else begin
      upd <= clr | (|inc);
      if (clr) begin
        A <= 4'd0;
        B <= 4'd0;
      end else begin
        if (inc[0]) A <= (A >= 4'd9) ? 4'd0 : A + 4'd1;
        if (inc[1]) B <= (B >= 4'd9) ? 4'd0 : B + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Scoreboard bench for bcd_operand_entry: each stimulus pushes the expected upd cycle
// and A/B values; the negedge monitor pops them when upd fires.
module tb_bcd_operand_entry;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  typedef struct {
    int cyc;
    int a;
    int b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_a = 1'b0, btn_b = 1'b0, btn_clr = 1'b0;
  logic [3:0] A, B;
  logic       upd;

  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  int   ma = 0, mb = 0;
  int   cur_a = 0, cur_b = 0;
  exp_t sb[$];
  exp_t mon_e;

  bcd_operand_entry #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst_n(rst_n), .btn_a(btn_a), .btn_b(btn_b), .btn_clr(btn_clr),
    .A(A), .B(B), .upd(upd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected increments for a raw level driven high from edge t and low from edge t+h.
  task automatic push_events(input bit pa, input bit pb, input bit pc, input int t, input int h);
    int k, u;
    k = 0;
    forever begin
      u = t + DB + 3 + k;
      if (u > t + h + DB + 2) break;
      if (pc) begin
        ma = 0;
        mb = 0;
      end else begin
        if (pa) ma = (ma + 1) % 10;
        if (pb) mb = (mb + 1) % 10;
      end
      sb.push_back('{u, ma, mb});
      if (pc || !(pa || pb)) break;
      k = (k == 0) ? RD : k + RR;
    end
  endtask

  task automatic press(input bit pa, input bit pb, input bit pc, input int h, input int gap);
    push_events(pa, pb, pc, cyc + 1, h);
    btn_a = pa;
    btn_b = pb;
    btn_clr = pc;
    tick(h);
    btn_a = 1'b0;
    btn_b = 1'b0;
    btn_clr = 1'b0;
    tick(gap);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_a = 0;
      cur_b = 0;
    end else begin
      if (upd) begin
        if (sb.size() == 0) begin
          chk("upd_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("upd_cycle", cyc, mon_e.cyc);
          cur_a = mon_e.a;
          cur_b = mon_e.b;
        end
      end
      chk("A_value", {28'd0, A}, cur_a);
      chk("B_value", {28'd0, B}, cur_b);
    end
  end

  initial begin
    int t;
    tick(3);
    chk("rst_A", {28'd0, A}, 0);
    chk("rst_B", {28'd0, B}, 0);
    chk("rst_upd", {31'd0, upd}, 0);
    rst_n = 1'b1;
    tick(3);

    // single press of A
    press(1, 0, 0, 10, 12);

    // glitches shorter than the debounce window
    repeat (5) begin
      btn_a = 1'b1;
      tick(3);
      btn_a = 1'b0;
      tick(3);
    end
    tick(10);

    // ten B presses wrap 9 -> 0
    repeat (10) press(0, 1, 0, 10, 10);

    // held A: first step, delayed repeat, then steady repeat
    press(1, 0, 0, DB + 2 + 60, 20);

    // simultaneous A and B steps bring A=5, B=7
    repeat (7) press(1, 1, 0, 10, 10);
    chk("pre_clr_A", {28'd0, A}, 5);
    chk("pre_clr_B", {28'd0, B}, 7);

    // clear and A debounce together: clear wins, one upd
    press(1, 0, 1, 10, 12);

    // reset mid-repeat with A held
    t = cyc + 1;
    push_events(1, 0, 0, t, 31);
    btn_a = 1'b1;
    tick(t + 37 - cyc);
    chk("pre_rst_A", {28'd0, A}, 3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_A", {28'd0, A}, 0);
    chk("async_rst_B", {28'd0, B}, 0);
    chk("async_rst_upd", {31'd0, upd}, 0);
    chk("async_rst_sb", sb.size(), 0);
    ma = 0;
    mb = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_events(1, 0, 0, cyc + 1, 28);
    tick(28);
    btn_a = 1'b0;
    tick(20);

    chk("sb_empty", sb.size(), 0);
    chk("final_A", {28'd0, A}, 2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
